// File: rtl/bios_loader.sv
// Boot-time copy sequencer: moves NEXTOR, FM-BIOS and PAC images from
// serial flash into SD-RAM. Bytes are read from flash one at a time and
// packed little-endian into 16-bit SD-RAM word writes. The MSX bus is held
// in wait until every enabled region has been copied.
`timescale 1ns/1ps
module bios_loader #(
  parameter bit          EN_NEXTOR   = 1'b1,
  parameter bit          EN_FM       = 1'b1,
  parameter bit          EN_PAC      = 1'b1,
  parameter logic [23:0] SRC_NEXTOR  = 24'h10_0000,
  parameter logic [23:0] DST_NEXTOR  = 24'h70_0000,
  parameter logic [23:0] SIZE_NEXTOR = 24'h02_0000,
  parameter logic [23:0] SRC_FM      = 24'h12_0000,
  parameter logic [23:0] DST_FM      = 24'h72_0000,
  parameter logic [23:0] SIZE_FM     = 24'h00_4000,
  parameter logic [23:0] SRC_PAC     = 24'h1F_0000,
  parameter logic [23:0] DST_PAC     = 24'h77_E000,
  parameter logic [23:0] SIZE_PAC    = 24'h00_2000,
  parameter int          START_DELAY = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        flash_req,
  output logic [23:0] flash_addr,
  input  logic        flash_valid,
  input  logic [7:0]  flash_rdata,
  output logic        ram_wr,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_ack,
  output logic        busy,
  output logic        done,
  output logic        bus_wait
);

  localparam logic [2:0] S_DELAY  = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_RD_LO  = 3'd2;
  localparam logic [2:0] S_RD_HI  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // A zero delay still spends one cycle in DELAY; the counter terminal
  // value is clamped so the compare stays well defined.
  localparam int DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int DW       = (DLY_LAST > 0) ? $clog2(DLY_LAST + 1) : 1;
  localparam logic [DW-1:0] DLY_END = DW'(DLY_LAST);

  localparam logic [2:0] EN_VEC = {EN_PAC, EN_FM, EN_NEXTOR};

  typedef struct packed {
    logic [23:0] src;
    logic [23:0] dst;
    logic [23:0] cnt;
  } region_t;

  // Odd or empty images cannot be packed into whole words.
  if (EN_NEXTOR && (SIZE_NEXTOR[0] || SIZE_NEXTOR == 24'd0)) begin : g_bad_nextor
    $fatal(1, "bios_loader: SIZE_NEXTOR must be even and nonzero");
  end
  if (EN_FM && (SIZE_FM[0] || SIZE_FM == 24'd0)) begin : g_bad_fm
    $fatal(1, "bios_loader: SIZE_FM must be even and nonzero");
  end
  if (EN_PAC && (SIZE_PAC[0] || SIZE_PAC == 24'd0)) begin : g_bad_pac
    $fatal(1, "bios_loader: SIZE_PAC must be even and nonzero");
  end

  logic [2:0]    state, state_nxt;
  logic [DW-1:0] dly_cnt;
  logic [1:0]    rgn;        // index of the next region still to consider
  logic [23:0]   src, dst, cnt;

  logic          sel_found;
  logic [1:0]    sel_idx;
  region_t       sel_desc;

  logic          flash_take, ram_take, dly_done;

  // Responses only count while the matching request is actually up.
  assign flash_take = flash_req & flash_valid;
  assign ram_take   = ram_wr & ram_ack;
  assign dly_done   = (state == S_DELAY) && (dly_cnt == DLY_END);

  // Pick the lowest-numbered enabled region at or after rgn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    sel_desc  = '0;
    for (int i = 2; i >= 0; i--) begin
      if (EN_VEC[i] && (i >= int'(rgn))) begin
        sel_found = 1'b1;
        sel_idx   = 2'(i);
      end
    end
    case (sel_idx)
      2'd0:    sel_desc = {SRC_NEXTOR, DST_NEXTOR, SIZE_NEXTOR >> 1};
      2'd1:    sel_desc = {SRC_FM,     DST_FM,     SIZE_FM     >> 1};
      default: sel_desc = {SRC_PAC,    DST_PAC,    SIZE_PAC    >> 1};
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_DELAY:  if (dly_done) state_nxt = S_SELECT;
      S_SELECT: state_nxt = sel_found ? S_RD_LO : S_FINISH;
      S_RD_LO:  if (flash_take) state_nxt = S_RD_HI;
      S_RD_HI:  if (flash_take) state_nxt = S_WRITE;
      S_WRITE:  if (ram_take) state_nxt = (cnt == 24'd1) ? S_SELECT : S_RD_LO;
      S_FINISH: if (start) state_nxt = S_DELAY;
      default:  state_nxt = S_DELAY;
    endcase
  end

  // State register; reset always lands in DELAY so the copy restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_DELAY;
    else       state <= state_nxt;
  end

  // Post-reset / post-start idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 dly_cnt <= '0;
    else if (state != S_DELAY) dly_cnt <= '0;
    else if (!dly_done)        dly_cnt <= dly_cnt + 1'b1;
    else                       dly_cnt <= '0;
  end

  // Region bookkeeping: source/destination pointers and remaining words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgn <= 2'd0;
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_SELECT: if (sel_found) begin
          src <= sel_desc.src;
          dst <= sel_desc.dst;
          cnt <= sel_desc.cnt;
          rgn <= sel_idx + 2'd1;
        end
        S_RD_LO, S_RD_HI: if (flash_take) src <= src + 24'd1;
        S_WRITE: if (ram_take) begin
          dst <= dst + 24'd2;
          cnt <= cnt - 24'd1;
        end
        S_FINISH: if (start) rgn <= 2'd0;
        default: ;
      endcase
    end
  end

  // Flash port: raise the request one cycle after entering a read state,
  // which also guarantees an idle cycle between consecutive requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_req  <= 1'b0;
      flash_addr <= '0;
    end else if (state == S_RD_LO || state == S_RD_HI) begin
      if (!flash_req) begin
        flash_req  <= 1'b1;
        flash_addr <= src;
      end else if (flash_valid) begin
        flash_req  <= 1'b0;
      end
    end
  end

  // SD-RAM port: assemble the word, then hold addr/data until acked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      if (state == S_RD_LO && flash_take) ram_wdata[7:0] <= flash_rdata;
      if (state == S_RD_HI && flash_take) begin
        ram_wdata[15:8] <= flash_rdata;
        ram_wr          <= 1'b1;
        ram_addr        <= dst & ~24'd1;
      end
      if (state == S_WRITE && ram_take) ram_wr <= 1'b0;
    end
  end

  // Status: busy and bus_wait track together; done holds until a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b1;
      bus_wait <= 1'b1;
      done     <= 1'b0;
    end else if (state == S_FINISH) begin
      busy     <= start;
      bus_wait <= start;
      done     <= ~start;
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
`timescale 1ns/1ps
module tb_bios_loader;
  localparam int SD = 4;
  localparam logic [23:0] SRC_N = 24'h10_0000, DST_N = 24'h70_0000, SZ_N = 24'd4;
  localparam logic [23:0] SRC_F = 24'h12_0000, DST_F = 24'h72_0000, SZ_F = 24'd2;
  localparam logic [23:0] SRC_P = 24'h1F_0000, DST_P = 24'h77_E000, SZ_P = 24'd2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start;
  // main instance (all regions)
  logic flash_req, flash_valid, ram_wr, ram_ack, busy, done, bus_wait;
  logic [23:0] flash_addr, ram_addr;
  logic [7:0] flash_rdata;
  logic [15:0] ram_wdata;
  // FM disabled
  logic b_start, b_flash_req, b_flash_valid, b_ram_wr, b_ram_ack, b_busy, b_done, b_bus_wait;
  logic [23:0] b_flash_addr, b_ram_addr;
  logic [7:0] b_flash_rdata;
  logic [15:0] b_ram_wdata;
  // all disabled
  logic c_start, c_flash_req, c_flash_valid, c_ram_wr, c_ram_ack, c_busy, c_done, c_bus_wait;
  logic [23:0] c_flash_addr, c_ram_addr;
  logic [7:0] c_flash_rdata;
  logic [15:0] c_ram_wdata;

  bios_loader #(.START_DELAY(SD),
    .SRC_NEXTOR(SRC_N), .DST_NEXTOR(DST_N), .SIZE_NEXTOR(SZ_N),
    .SRC_FM(SRC_F), .DST_FM(DST_F), .SIZE_FM(SZ_F),
    .SRC_PAC(SRC_P), .DST_PAC(DST_P), .SIZE_PAC(SZ_P)) u_dut (
    .clk(clk), .reset(reset), .start(start), .flash_req(flash_req), .flash_addr(flash_addr),
    .flash_valid(flash_valid), .flash_rdata(flash_rdata), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .busy(busy), .done(done), .bus_wait(bus_wait));

  bios_loader #(.START_DELAY(SD), .EN_FM(1'b0),
    .SRC_NEXTOR(SRC_N), .DST_NEXTOR(DST_N), .SIZE_NEXTOR(SZ_N),
    .SRC_FM(SRC_F), .DST_FM(DST_F), .SIZE_FM(SZ_F),
    .SRC_PAC(SRC_P), .DST_PAC(DST_P), .SIZE_PAC(SZ_P)) u_nofm (
    .clk(clk), .reset(reset), .start(b_start), .flash_req(b_flash_req), .flash_addr(b_flash_addr),
    .flash_valid(b_flash_valid), .flash_rdata(b_flash_rdata), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_ack(b_ram_ack), .busy(b_busy), .done(b_done), .bus_wait(b_bus_wait));

  bios_loader #(.START_DELAY(SD), .EN_NEXTOR(1'b0), .EN_FM(1'b0), .EN_PAC(1'b0)) u_none (
    .clk(clk), .reset(reset), .start(c_start), .flash_req(c_flash_req), .flash_addr(c_flash_addr),
    .flash_valid(c_flash_valid), .flash_rdata(c_flash_rdata), .ram_wr(c_ram_wr), .ram_addr(c_ram_addr),
    .ram_wdata(c_ram_wdata), .ram_ack(c_ram_ack), .busy(c_busy), .done(c_done), .bus_wait(c_bus_wait));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: every enabled region becomes SIZE/2 word writes at
  // consecutive even addresses; the flash model returns addr[7:0] per byte.
  logic [39:0] exp_a[$], exp_b[$], cap_a[$], cap_b[$];

  task automatic build_exp(input bit to_b, input bit en_n, input bit en_f, input bit en_p);
    logic [23:0] srcs[3], dsts[3], szs[3];
    bit ens[3];
    logic [23:0] s, s1, d;
    srcs = '{SRC_N, SRC_F, SRC_P};
    dsts = '{DST_N, DST_F, DST_P};
    szs  = '{SZ_N, SZ_F, SZ_P};
    ens  = '{en_n, en_f, en_p};
    for (int r = 0; r < 3; r++) begin
      if (ens[r]) begin
        for (int w = 0; w < int'(szs[r]) / 2; w++) begin
          s  = srcs[r] + 24'(2 * w);
          s1 = s + 24'd1;
          d  = dsts[r] + 24'(2 * w);
          if (to_b) exp_b.push_back({d, s1[7:0], s[7:0]});
          else      exp_a.push_back({d, s1[7:0], s[7:0]});
        end
      end
    end
  endtask

  task automatic cmp_seq(input bit sel);
    int n;
    if (sel) begin
      chk("nofm_write_count", 64'(cap_b.size()), 64'(exp_b.size()));
      n = (cap_b.size() < exp_b.size()) ? cap_b.size() : exp_b.size();
      for (int i = 0; i < n; i++) chk($sformatf("nofm_write[%0d]", i), 64'(cap_b[i]), 64'(exp_b[i]));
    end else begin
      chk("write_count", 64'(cap_a.size()), 64'(exp_a.size()));
      n = (cap_a.size() < exp_a.size()) ? cap_a.size() : exp_a.size();
      for (int i = 0; i < n; i++) chk($sformatf("write[%0d]", i), 64'(cap_a[i]), 64'(exp_a[i]));
    end
  endtask

  // Main-instance flash/ram responders with latency control and hold checks.
  bit rand_mode = 0, spur = 0;
  int fl_lat_cfg = 0, ack_lat_cfg = 0;
  bit f_busy = 0, f_done = 0, r_busy = 0, r_done = 0;
  int f_cnt = 0, r_cnt = 0;
  logic [23:0] f_addr, r_addr;
  logic [15:0] r_data;

  always @(negedge clk) begin
    flash_valid = 1'b0;
    ram_ack     = 1'b0;
    if (f_done) begin
      chk("flash_gap", 64'(flash_req), 64'd0);
      f_busy = 0; f_done = 0;
    end else if (flash_req) begin
      if (!f_busy) begin
        f_busy = 1; f_addr = flash_addr;
        f_cnt = rand_mode ? int'($urandom_range(0, 7)) : fl_lat_cfg;
      end else chk("flash_addr_hold", 64'(flash_addr), 64'(f_addr));
      if (f_cnt == 0) begin
        flash_valid = 1'b1; flash_rdata = flash_addr[7:0]; f_done = 1;
      end else f_cnt--;
    end else begin
      f_busy = 0;
      if (spur && $urandom_range(0, 3) == 0) begin
        flash_valid = 1'b1; flash_rdata = 8'($urandom);
      end
    end
    if (r_done) begin
      chk("ram_wr_drop", 64'(ram_wr), 64'd0);
      r_busy = 0; r_done = 0;
    end else if (ram_wr) begin
      if (!r_busy) begin
        r_busy = 1; r_addr = ram_addr; r_data = ram_wdata;
        r_cnt = rand_mode ? int'($urandom_range(0, 9)) : ack_lat_cfg;
      end else begin
        chk("ram_addr_hold", 64'(ram_addr), 64'(r_addr));
        chk("ram_data_hold", 64'(ram_wdata), 64'(r_data));
      end
      if (r_cnt == 0) begin
        ram_ack = 1'b1; r_done = 1;
        cap_a.push_back({ram_addr, ram_wdata});
      end else r_cnt--;
    end else begin
      r_busy = 0;
      if (spur && $urandom_range(0, 3) == 0) ram_ack = 1'b1;
    end
  end

  // FM-disabled instance: fixed one-cycle responders, watch for FM traffic.
  bit b_fd = 0, b_rd = 0;
  int b_fm_hits = 0;
  always @(negedge clk) begin
    b_flash_valid = 1'b0;
    b_ram_ack     = 1'b0;
    if (b_flash_req && b_flash_addr[23:16] == 8'h12) b_fm_hits++;
    if (b_ram_wr && b_ram_addr[23:16] == 8'h72) b_fm_hits++;
    if (b_flash_req && !b_fd) begin
      b_flash_valid = 1'b1; b_flash_rdata = b_flash_addr[7:0]; b_fd = 1;
    end else if (!b_flash_req) b_fd = 0;
    if (b_ram_wr && !b_rd) begin
      b_ram_ack = 1'b1; b_rd = 1; cap_b.push_back({b_ram_addr, b_ram_wdata});
    end else if (!b_ram_wr) b_rd = 0;
  end

  int c_act = 0;
  always @(negedge clk) if (c_flash_req || c_ram_wr) c_act++;

  typedef struct {
    int fl_lat;
    int ack_lat;
    logic [23:0] addr;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[4];

  task automatic wait_cap(input int n, input int budget);
    int t = 0;
    while (cap_a.size() < n && t < budget) begin @(negedge clk); t++; end
    chk($sformatf("wait_write_%0d", n), 64'(cap_a.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin @(negedge clk); t++; end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 24'h70_0000, 16'h0100};
    tbl[1] = '{2, 3, 24'h70_0002, 16'h0302};
    tbl[2] = '{1, 0, 24'h72_0000, 16'h0100};
    tbl[3] = '{5, 9, 24'h77_E000, 16'h0100};
    reset = 1'b1; start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    c_flash_valid = 1'b0; c_flash_rdata = 8'h00; c_ram_ack = 1'b0;
    flash_valid = 1'b0; flash_rdata = 8'h00; ram_ack = 1'b0;
    b_flash_valid = 1'b0; b_flash_rdata = 8'h00; b_ram_ack = 1'b0;
    build_exp(1'b0, 1'b1, 1'b1, 1'b1);
    build_exp(1'b1, 1'b1, 1'b0, 1'b1);
    fl_lat_cfg = tbl[0].fl_lat; ack_lat_cfg = tbl[0].ack_lat;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_flash_req", 64'(flash_req), 0); chk("rst_flash_addr", 64'(flash_addr), 0);
    chk("rst_ram_wr", 64'(ram_wr), 0);       chk("rst_ram_addr", 64'(ram_addr), 0);
    chk("rst_ram_wdata", 64'(ram_wdata), 0); chk("rst_busy", 64'(busy), 1);
    chk("rst_done", 64'(done), 0);           chk("rst_bus_wait", 64'(bus_wait), 1);
    reset = 1'b0;

    // cycle-exact delay / empty-run timing
    for (int k = 1; k <= SD + 2; k++) begin
      @(negedge clk);
      if (k == SD + 1) begin
        chk("none_done_early", 64'(c_done), 0);
        chk("first_req_early", 64'(flash_req), 0);
      end
      if (k == SD + 2) begin
        chk("none_done", 64'(c_done), 1);
        chk("none_busy", 64'(c_busy), 0);
        chk("none_bus_wait", 64'(c_bus_wait), 0);
        chk("first_req", 64'(flash_req), 1);
        chk("first_addr", 64'(flash_addr), 64'(SRC_N));
      end
    end

    // table-driven in-order writes with per-word latencies
    for (int i = 0; i < 4; i++) begin
      fl_lat_cfg = tbl[i].fl_lat; ack_lat_cfg = tbl[i].ack_lat;
      wait_cap(i + 1, 300);
      if (cap_a.size() > i) begin
        chk($sformatf("tbl_addr[%0d]", i), 64'(cap_a[i][39:16]), 64'(tbl[i].addr));
        chk($sformatf("tbl_data[%0d]", i), 64'(cap_a[i][15:0]), 64'(tbl[i].data));
      end
    end
    wait_done(300);
    chk("fin_busy", 64'(busy), 0); chk("fin_bus_wait", 64'(bus_wait), 0);
    chk("fin_count", 64'(cap_a.size()), 64'd4);
    cmp_seq(1'b0);
    begin
      int t = 0;
      while (!b_done && t < 300) begin @(negedge clk); t++; end
    end
    chk("nofm_done", 64'(b_done), 1);
    chk("nofm_fm_traffic", 64'(b_fm_hits), 0);
    cmp_seq(1'b1);
    chk("none_activity", 64'(c_act), 0);

    // restart with random latencies and stray responses; start during DELAY
    rand_mode = 1; spur = 1; cap_a.delete();
    pulse_start();
    chk("start_done_fall", 64'(done), 0);
    chk("start_busy", 64'(busy), 1);
    chk("start_bus_wait", 64'(bus_wait), 1);
    @(negedge clk); @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("restart_req_early", 64'(flash_req), 0);
    @(negedge clk);
    chk("restart_req_time", 64'(flash_req), 1);
    wait_cap(2, 500);
    pulse_start();   // ignored while copying
    wait_done(2000);
    cmp_seq(1'b0);

    // reset in the middle of the second NEXTOR word
    cap_a.delete();
    pulse_start();
    wait_cap(1, 500);
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_flash_req", 64'(flash_req), 0); chk("mid_flash_addr", 64'(flash_addr), 0);
    chk("mid_ram_wr", 64'(ram_wr), 0);       chk("mid_ram_addr", 64'(ram_addr), 0);
    chk("mid_ram_wdata", 64'(ram_wdata), 0); chk("mid_busy", 64'(busy), 1);
    chk("mid_done", 64'(done), 0);           chk("mid_bus_wait", 64'(bus_wait), 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    cap_a.delete();
    begin
      int t = 0;
      while (!flash_req && t < 100) begin @(negedge clk); t++; end
    end
    chk("rerun_req", 64'(flash_req), 1);
    chk("rerun_addr", 64'(flash_addr), 64'(SRC_N));
    wait_done(2000);
    cmp_seq(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bios_loader.md
Name: bios_loader

Overview:
- Boot-time copy sequencer. After reset it copies the NEXTOR BIOS, the FM-BIOS and the PAC image from serial flash into SD-RAM.
- It sits between the flash reader and one SD-RAM write port, and holds the MSX bus in wait until the images are in place.
- Copies are byte reads from flash, packed into 16-bit SD-RAM word writes. Regions run in fixed order: NEXTOR, then FM, then PAC.

Parameters:
- EN_NEXTOR, 1, copy NEXTOR region (0 = skip)
- EN_FM, 1, copy FM-BIOS region (0 = skip)
- EN_PAC, 1, copy PAC region (0 = skip)
- SRC_NEXTOR, 24'h10_0000, flash byte address of NEXTOR
- DST_NEXTOR, 24'h70_0000, SD-RAM byte address of NEXTOR
- SIZE_NEXTOR, 24'h02_0000, NEXTOR bytes (even, nonzero)
- SRC_FM, 24'h12_0000, flash byte address of FM-BIOS
- DST_FM, 24'h72_0000, SD-RAM byte address of FM-BIOS
- SIZE_FM, 24'h00_4000, FM-BIOS bytes
- SRC_PAC, 24'h1F_0000, flash byte address of PAC
- DST_PAC, 24'h77_E000, SD-RAM byte address of PAC
- SIZE_PAC, 24'h00_2000, PAC bytes
- START_DELAY, 1024, idle cycles after reset release before the first flash request

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-high reset
- start, in, 1, one-cycle pulse that reruns the full copy; ignored while busy
- flash_req, out, 1, flash read request
- flash_addr, out, 24, flash byte address
- flash_valid, in, 1, one-cycle pulse: flash_rdata valid, request complete
- flash_rdata, in, 8, flash read byte
- ram_wr, out, 1, SD-RAM write request
- ram_addr, out, 24, SD-RAM byte address (always even)
- ram_wdata, out, 16, write word
- ram_ack, in, 1, one-cycle pulse: write accepted
- busy, out, 1, copy in progress, including the delay phase
- done, out, 1, all enabled regions copied; stays high until the next start or reset
- bus_wait, out, 1, MSX wait request, equal to busy

Behaviour:
- All outputs are registered.
- Reset values: flash_req=0, flash_addr=0, ram_wr=0, ram_addr=0, ram_wdata=0, busy=1, done=0, bus_wait=1.
- States: DELAY, SELECT, RD_LO, RD_HI, WRITE, FINISH.
- DELAY: counts START_DELAY cycles, then goes to SELECT. This is entered on reset release and on an accepted start pulse.
- SELECT: loads src, dst and a word count (SIZE/2) for the next enabled region, then goes to RD_LO. If no enabled region remains, goes to FINISH.
- RD_LO:
  - flash_req=1, flash_addr=src.
  - Hold both until flash_valid.
  - On flash_valid: latch rdata into ram_wdata[7:0], drop req for one cycle, src+=1, go to RD_HI.
- RD_HI: same handshake; the byte goes to ram_wdata[15:8] (little-endian), then go to WRITE.
- WRITE:
  - ram_wr=1, ram_addr=dst; addr and data held stable until ram_ack.
  - On ram_ack: ram_wr=0, dst+=2, count-=1.
  - count==0 → SELECT, else → RD_LO.
- FINISH: busy=0, bus_wait=0, done=1. A start pulse clears done, sets busy, and enters DELAY.
- Handshake responses are sampled only while the matching request is high. flash_valid while flash_req=0 is ignored, and so is ram_ack while ram_wr=0.
- Earliest response is the cycle after the request asserts. A response in the same cycle as assertion cannot occur, because outputs are registered.
- Minimum spacing: consecutive flash requests are separated by at least one idle cycle.
- Arithmetic: src, dst and count are 24-bit. Address increments wrap modulo 2^24 with no error flag. Parameters are checked at elaboration: SIZE must be even and nonzero; an odd SIZE is a fatal assertion.
- Disabled regions are skipped with no bus activity. With all three disabled: DELAY → SELECT → FINISH, done at START_DELAY+2 cycles.
- Reset mid-copy: all outputs return to reset values immediately (asynchronous). The copy restarts from the first region after DELAY. A partial SD-RAM write may remain and is overwritten.
- start during busy has no effect. start in the same cycle as the transition into FINISH is ignored.

Test Plan:
- Reset release, START_DELAY=4, sizes 4/2/2, flash model returns the low byte of the address, 1-cycle latency → ram writes in order:
  - 0x700000=0x0100, 0x700002=0x0302
  - 0x720000=0x0100
  - 0x77E000=0x0100
  - then done=1, busy=0, 4 writes total.
- EN_FM=0, same setup → FM region produces no flash_req at 0x120000 and no writes to 0x72xxxx; NEXTOR and PAC writes unchanged.
- Flash latency 0–7 cycles random, ram_ack delay 0–9 cycles random → identical write sequence; flash_addr and ram_addr/ram_wdata stable while their request is high.
- reset asserted during the second NEXTOR word → outputs return to reset values that same cycle; after re-release the sequence restarts at flash_addr 0x100000.
- After done, start pulse → done falls next cycle, busy=1, the full sequence repeats; a second start while busy is ignored (no extra DELAY).
- All regions disabled, START_DELAY=4 → no requests; done=1 at cycle 6 after reset release.
